// File: rtl/univ_shift_reg_n.sv
// W-bit universal shift register: single-cycle LOAD/CLEAR/NOP and multi-step
// shift/rotate/arithmetic-shift, one bit per clock, with a start/busy/done handshake.
module univ_shift_reg_n #(
  parameter  int W  = 8,
  localparam int AW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [W-1:0]  din,
  input  logic          lsi,
  input  logic          rsi,
  input  logic          hold,
  output logic [W-1:0]  q,
  output logic          so_msb,
  output logic          so_lsb,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SHL   = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_ROL   = 3'b011;
  localparam logic [2:0] OP_ROR   = 3'b100;
  localparam logic [2:0] OP_ASR   = 3'b101;
  localparam logic [2:0] OP_LOAD  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [2:0]    op_r, op_n;
  logic [W-1:0]  q_n;
  logic          done_n;
  logic [AW-1:0] amt_c;

  // One single-bit step of the latched operation.
  function automatic logic [W-1:0] shift_step(input logic [2:0] o, input logic [W-1:0] v,
                                              input logic l, input logic r);
    logic signed [W-1:0] sv;
    logic [W-1:0]        res;
    sv  = v;
    res = v;
    case (o)
      OP_SHL:  res = {v[W-2:0], l};
      OP_SHR:  res = {r, v[W-1:1]};
      OP_ROL:  res = {v[W-2:0], v[W-1]};
      OP_ROR:  res = {v[0], v[W-1:1]};
      OP_ASR:  res = sv >>> 1;
      default: res = v;
    endcase
    return res;
  endfunction

  // Step counts beyond the register width are clamped to W.
  assign amt_c = (amt > AW'(W)) ? AW'(W) : amt;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_r;
    q_n     = q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_NOP:   done_n = 1'b1;
            OP_LOAD:  begin q_n = din; done_n = 1'b1; end
            OP_CLEAR: begin q_n = '0;  done_n = 1'b1; end
            default: begin
              op_n = op;
              if (amt_c == '0) begin
                done_n = 1'b1;
              end else begin
                cnt_n   = amt_c;
                state_n = RUN;
              end
            end
          endcase
        end
      end
      RUN: begin
        if (!hold) begin
          q_n   = shift_step(op_r, q, lsi, rsi);
          cnt_n = cnt - AW'(1);
          if (cnt == AW'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= OP_NOP;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_r  <= op_n;
      q     <= q_n;
      done  <= done_n;
    end
  end

  assign busy   = (state == RUN);
  assign so_msb = q[W-1];
  assign so_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Self-checking bench for univ_shift_reg_n (W=8): directed scenarios plus a
// randomized run compared against an arithmetic reference model.
module tb_univ_shift_reg_n;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, lsi, rsi, hold;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [W-1:0]  din, q;
  logic          so_msb, so_lsb, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  univ_shift_reg_n #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .din(din),
    .lsi(lsi), .rsi(rsi), .hold(hold), .q(q), .so_msb(so_msb), .so_lsb(so_lsb),
    .busy(busy), .done(done)
  );

  // Reference step using plain integer arithmetic on the register value.
  function automatic logic [7:0] ref_step(input int o, input int m, input int l, input int r);
    int res;
    case (o)
      1:       res = (m * 2 + l) % 256;
      2:       res = m / 2 + r * 128;
      3:       res = (m * 2) % 256 + m / 128;
      4:       res = m / 2 + (m % 2) * 128;
      5:       res = m / 2 + (m / 128) * 128;
      default: res = m;
    endcase
    return res[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; op = 3'd0; amt = '0; din = '0; lsi = 1'b0; rsi = 1'b0; hold = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    start = 1'b1; op = 3'd6; din = v;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q got %h want 00", q); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    #10 rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    start = 1'b1; op = 3'd6; din = 8'hA5; hold = 1'b1;
    tick();
    start = 1'b0; hold = 1'b0;
    tests++; if (q !== 8'hA5) begin fails++; $display("FAIL load_q got %h want a5", q); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL load_done got %b want 1", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL load_busy got %b want 0", busy); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL load_done_pulse got %b want 0", done); end
  endtask

  task automatic test_shl();
    logic [7:0] e [3];
    e = '{8'h4B, 8'h97, 8'h2F};
    load(8'hA5);
    start = 1'b1; op = 3'd1; amt = 4'd3; lsi = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (q !== 8'hA5 || busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL shl_accept got q=%h busy=%b done=%b want a5 1 0", q, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (q !== e[i] || busy !== (i < 2) || done !== (i == 2)) begin
        fails++; $display("FAIL shl_step%0d got q=%h busy=%b done=%b want %h %b %b",
                          i, q, busy, done, e[i], (i < 2), (i == 2));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_asr_rol();
    int steps;
    load(8'h96);
    start = 1'b1; op = 3'd5; amt = 4'd2;
    tick();
    start = 1'b0;
    tick();
    tests++; if (q !== 8'hCB) begin fails++; $display("FAIL asr_step1 got %h want cb", q); end
    tick();
    tests++; if (q !== 8'hE5 || done !== 1'b1) begin
      fails++; $display("FAIL asr_step2 got q=%h done=%b want e5 1", q, done);
    end
    load(8'hA5);
    start = 1'b1; op = 3'd3; amt = 4'd12;
    tick();
    start = 1'b0;
    steps = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      steps++;
      if (!busy) break;
    end
    tests++; if (steps !== 8) begin fails++; $display("FAIL rol12_steps got %0d want 8", steps); end
    tests++; if (q !== 8'hA5 || done !== 1'b1) begin
      fails++; $display("FAIL rol12_final got q=%h done=%b want a5 1", q, done);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_hold_ror();
    int b;
    load(8'hA5);
    start = 1'b1; op = 3'd4; amt = 4'd4;
    tick();
    b = busy ? 1 : 0;
    op = 3'd6; din = 8'h00;  // start stays high: must be ignored while busy
    tick(); b += busy ? 1 : 0;
    start = 1'b0;
    tests++; if (q !== 8'hD2) begin fails++; $display("FAIL ror_step1 got %h want d2", q); end
    tick(); b += busy ? 1 : 0;
    tests++; if (q !== 8'h69) begin fails++; $display("FAIL ror_step2 got %h want 69", q); end
    hold = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); b += busy ? 1 : 0;
      tests++; if (q !== 8'h69 || busy !== 1'b1) begin
        fails++; $display("FAIL ror_hold%0d got q=%h busy=%b want 69 1", i, q, busy);
      end
    end
    hold = 1'b0; start = 1'b0;
    tick(); b += busy ? 1 : 0;
    tests++; if (q !== 8'hB4) begin fails++; $display("FAIL ror_step3 got %h want b4", q); end
    tick(); b += busy ? 1 : 0;
    tests++; if (q !== 8'h5A || done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL ror_final got q=%h done=%b busy=%b want 5a 1 0", q, done, busy);
    end
    tests++; if (b !== 6) begin fails++; $display("FAIL ror_busy_cycles got %0d want 6", b); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    load(8'hA5);
    start = 1'b1; op = 3'd2; amt = 4'd5; rsi = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    tests++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL midrst got q=%h busy=%b done=%b want 00 0 0", q, busy, done);
    end
    #1 rst = 1'b0;
    tick();
    tests++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL midrst_after got q=%h busy=%b done=%b want 00 0 0", q, busy, done);
    end
    load(8'h3C);
    tests++; if (q !== 8'h3C || done !== 1'b1) begin
      fails++; $display("FAIL midrst_restart got q=%h done=%b want 3c 1", q, done);
    end
    start = 1'b1; op = 3'd2; amt = 4'd1; rsi = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++; if (q !== 8'h9E || done !== 1'b1) begin
      fails++; $display("FAIL midrst_shr got q=%h done=%b want 9e 1", q, done);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int m, o, a, n, rem, cyc;
    m = q;
    for (int it = 0; it < 60; it++) begin
      o = $urandom_range(0, 7);
      a = $urandom_range(0, 15);
      start = 1'b1; op = 3'(o); amt = 4'(a); din = 8'($urandom);
      hold = 1'($urandom); lsi = 1'($urandom); rsi = 1'($urandom);
      tick();
      start = 1'b0; hold = 1'b0;
      n = (a > W) ? W : a;
      if (o == 6) m = din;
      else if (o == 7) m = 0;
      rem = (o == 0 || o >= 6) ? 0 : n;
      tests++; if (q !== 8'(m) || busy !== (rem > 0) || done !== (rem == 0)) begin
        fails++; $display("FAIL rand_accept it=%0d op=%0d amt=%0d got q=%h busy=%b done=%b want %h %b %b",
                          it, o, a, q, busy, done, 8'(m), (rem > 0), (rem == 0));
      end
      cyc = 0;
      while (rem > 0 && cyc < 64) begin
        hold  = ($urandom_range(0, 3) == 0);
        lsi   = 1'($urandom);
        rsi   = 1'($urandom);
        start = 1'($urandom);
        op    = 3'($urandom);
        amt   = 4'($urandom);
        din   = 8'($urandom);
        tick();
        cyc++;
        if (!hold) begin
          m = ref_step(o, m, int'(lsi), int'(rsi));
          rem--;
        end
        tests++; if (q !== 8'(m) || busy !== (rem > 0) || done !== (rem == 0) ||
                     so_msb !== m[7] || so_lsb !== m[0]) begin
          fails++; $display("FAIL rand_step it=%0d op=%0d rem=%0d got q=%h busy=%b done=%b want %h %b %b",
                            it, o, rem, q, busy, done, 8'(m), (rem > 0), (rem == 0));
        end
      end
      if (rem > 0) begin
        tests++; fails++; $display("FAIL rand_timeout it=%0d rem=%0d want 0", it, rem);
      end
      idle_inputs();
      if ($urandom_range(0, 2) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl();
    test_asr_rol();
    test_hold_ror();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
